// File: rtl/core_mem_responder.sv
// Memory-side responder for a single-cycle core: zero-latency fetch/data reads, byte-lane stores,
// a boot-load FSM and a tohost halt register. Optional bounds-error ports under MEM_BOUNDS_ERR_EN.
module core_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_0000,
  parameter bit          BOOT_LOAD   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr1,
  input  logic [31:0] mem_addr2,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_wr_data,
  input  logic [3:0]  mem_byte_en,
  output logic [31:0] mem_rd_data1,
  output logic [31:0] mem_rd_data2,
  output logic        core_hold,
  input  logic        init_valid,
  input  logic [31:0] init_data,
  input  logic        init_last,
  output logic        init_ready,
  output logic [31:0] tohost_data,
  output logic        tohost_done
`ifdef MEM_BOUNDS_ERR_EN
  ,
  output logic        err_oob,
  output logic [31:0] err_addr
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    ST_INIT_LOAD = 2'd0,
    ST_RUN       = 2'd1,
    ST_HALT      = 2'd2
  } state_e;

  localparam state_e RST_STATE = BOOT_LOAD ? ST_INIT_LOAD : ST_RUN;

  state_e        state_q, state_d;
  logic [AW-1:0] load_ptr_q, load_ptr_d;
  logic [31:0]   tohost_data_q, tohost_data_d;
  logic          tohost_done_q, tohost_done_d;

  logic          in_range1, in_range2, is_tohost2;
  logic [AW-1:0] idx1, idx2;
  logic          init_accept, core_wr, tohost_wr;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_we;
  logic [31:0]   rd1_word, rd2_word;

  // Address decode; the low two address bits are ignored on purpose.
  always_comb begin
    in_range1  = {1'b0, mem_addr1} < RAM_BYTES;
    in_range2  = {1'b0, mem_addr2} < RAM_BYTES;
    is_tohost2 = (mem_addr2 == TOHOST_ADDR);
    idx1       = mem_addr1[2 +: AW];
    idx2       = mem_addr2[2 +: AW];
  end

  always_comb begin
    init_accept = (state_q == ST_INIT_LOAD) && init_valid;
    core_wr     = (state_q == ST_RUN) && mem_wr_en;
    tohost_wr   = core_wr && is_tohost2;
    ram_waddr   = idx2;
    ram_wdata   = mem_wr_data;
    ram_we      = 4'b0000;
    if (init_accept) begin
      ram_waddr = load_ptr_q;
      ram_wdata = init_data;
      ram_we    = 4'b1111;
    end else if (core_wr && in_range2) begin
      ram_we    = mem_byte_en;
    end
  end

  // One byte-wide array per lane keeps each lane's write enable independent.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram_b [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (ram_we[gi]) begin
          ram_b[ram_waddr] <= ram_wdata[8*gi +: 8];
        end
      end

      assign rd1_word[8*gi +: 8] = ram_b[idx1];
      assign rd2_word[8*gi +: 8] = ram_b[idx2];
    end
  endgenerate

  always_comb begin
    mem_rd_data1 = in_range1 ? rd1_word : 32'h0;
    if (is_tohost2) begin
      mem_rd_data2 = tohost_data_q;
    end else if (in_range2) begin
      mem_rd_data2 = rd2_word;
    end else begin
      mem_rd_data2 = 32'h0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RST_STATE;
      load_ptr_q    <= '0;
      tohost_data_q <= 32'h0;
      tohost_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_ptr_q    <= load_ptr_d;
      tohost_data_q <= tohost_data_d;
      tohost_done_q <= tohost_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT_LOAD: begin
        if (init_accept && (init_last || load_ptr_q == LAST_PTR)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tohost_wr && mem_wr_data[0]) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = RST_STATE;
    endcase
  end

  // Load pointer saturates at the last word; the FSM leaves INIT_LOAD there anyway.
  always_comb begin
    load_ptr_d    = load_ptr_q;
    tohost_data_d = tohost_data_q;
    tohost_done_d = tohost_done_q;
    if (init_accept && load_ptr_q != LAST_PTR) begin
      load_ptr_d = load_ptr_q + 1'b1;
    end
    if (tohost_wr) begin
      tohost_data_d = mem_wr_data;
      tohost_done_d = tohost_done_q | mem_wr_data[0];
    end
  end

  // Output logic
  always_comb begin
    core_hold  = 1'b1;
    init_ready = 1'b0;
    case (state_q)
      ST_INIT_LOAD: begin
        core_hold  = 1'b1;
        init_ready = 1'b1;
      end
      ST_RUN: begin
        core_hold  = 1'b0;
        init_ready = 1'b0;
      end
      default: begin
        core_hold  = 1'b1;
        init_ready = 1'b0;
      end
    endcase
  end

  assign tohost_data = tohost_data_q;
  assign tohost_done = tohost_done_q;

`ifdef MEM_BOUNDS_ERR_EN
  logic        err_oob_q, err_oob_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        off1, off2;

  // Only the first offending address is kept; port 1 wins a same-cycle tie.
  always_comb begin
    off1       = !in_range1 && (mem_addr1 != TOHOST_ADDR);
    off2       = !in_range2 && !is_tohost2;
    err_oob_d  = err_oob_q;
    err_addr_d = err_addr_q;
    if (state_q == ST_RUN && !err_oob_q) begin
      if (off1) begin
        err_oob_d  = 1'b1;
        err_addr_d = mem_addr1;
      end else if (off2) begin
        err_oob_d  = 1'b1;
        err_addr_d = mem_addr2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_oob_q  <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      err_oob_q  <= err_oob_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_oob  = err_oob_q;
  assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_core_mem_responder.sv
// Self-checking bench for core_mem_responder: scenario tasks with a scoreboard queue of
// expected read data, filled as stimulus is driven and drained as reads are sampled.
module tb_core_mem_responder;

  localparam logic [31:0] TOHOST = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr1 = '0, mem_addr2 = '0;
  logic        mem_wr_en = 1'b0;
  logic [31:0] mem_wr_data = '0;
  logic [3:0]  mem_byte_en = '0;
  logic [31:0] mem_rd_data1, mem_rd_data2;
  logic        core_hold;
  logic        init_valid = 1'b0;
  logic [31:0] init_data = '0;
  logic        init_last = 1'b0;
  logic        init_ready;
  logic [31:0] tohost_data;
  logic        tohost_done;
`ifdef MEM_BOUNDS_ERR_EN
  logic        err_oob;
  logic [31:0] err_addr;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  core_mem_responder #(
    .DEPTH_WORDS(4096),
    .TOHOST_ADDR(TOHOST),
    .BOOT_LOAD(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en),
    .mem_rd_data1(mem_rd_data1), .mem_rd_data2(mem_rd_data2),
    .core_hold(core_hold),
    .init_valid(init_valid), .init_data(init_data), .init_last(init_last),
    .init_ready(init_ready),
    .tohost_data(tohost_data), .tohost_done(tohost_done)
`ifdef MEM_BOUNDS_ERR_EN
    , .err_oob(err_oob), .err_addr(err_addr)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    @(negedge clk);
    got = {28'h0, core_hold, init_ready, tohost_done, 1'b0};
    n_cmp++;
    if (got !== 32'hC) begin
      n_err++;
      $display("FAIL reset_flags got=%h exp=%h", got, 32'hC);
    end
    n_cmp++;
    if (tohost_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_tohost got=%h exp=0", tohost_data);
    end
    $display("reset: hold=%b ready=%b tohost=%h", core_hold, init_ready, tohost_data);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midload();
    init_valid = 1'b1;
    init_data = 32'hA1;
    step();
    init_data = 32'hA2;
    step();
    init_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (init_ready !== 1'b1 || core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL midload_reset ready=%b hold=%b exp 1/1", init_ready, core_hold);
    end
    $display("midload reset: ready=%b hold=%b", init_ready, core_hold);
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_boot_load();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      init_valid = 1'b1;
      init_data = words[i];
      init_last = (i == 2);
      @(negedge clk);
      n_cmp++;
      if (core_hold !== 1'b1 || init_ready !== 1'b1) begin
        n_err++;
        $display("FAIL boot_hold_word%0d hold=%b ready=%b exp 1/1", i, core_hold, init_ready);
      end
      $display("boot: word %0d = %h offered", i, words[i]);
      step();
    end
    init_valid = 1'b0;
    init_last = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (core_hold !== 1'b0 || init_ready !== 1'b0) begin
      n_err++;
      $display("FAIL boot_release hold=%b ready=%b exp 0/0", core_hold, init_ready);
    end
    // Word 0 reads 0x11 only if the mid-load reset restarted the pointer at zero.
    for (int i = 0; i < 3; i++) exp_q.push_back(words[i]);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      mem_addr1 = 32'(i * 4);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_data1 !== e) begin
        n_err++;
        $display("FAIL boot_fetch_%0h got=%h exp=%h", mem_addr1, mem_rd_data1, e);
      end
      $display("boot: fetch %h -> %h", mem_addr1, mem_rd_data1);
    end
    step();
  endtask

  task automatic test_init_ignored();
    mem_addr2 = 32'h0C;
    mem_wr_en = 1'b1; mem_wr_data = 32'h1234_5678; mem_byte_en = 4'hF;
    step();
    mem_wr_en = 1'b0;
    init_valid = 1'b1; init_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    n_cmp++;
    if (init_ready !== 1'b0) begin
      n_err++;
      $display("FAIL run_init_ready got=%b exp=0", init_ready);
    end
    step();
    init_valid = 1'b0;
    @(negedge clk);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_data2 !== e) begin
        n_err++;
        $display("FAIL run_init_ignored got=%h exp=%h", mem_rd_data2, e);
      end
    end
    $display("run: init ignored, word 0xC = %h", mem_rd_data2);
  endtask

  task automatic test_byte_enable();
    mem_addr2 = 32'h10;
    mem_wr_en = 1'b1; mem_wr_data = 32'hAABB_CCDD; mem_byte_en = 4'b1111;
    step();
    mem_wr_data = 32'h0000_0099; mem_byte_en = 4'b0001;
    step();
    mem_wr_data = 32'h5555_5555; mem_byte_en = 4'b0000;
    exp_q.push_back(32'hAABB_CC99);
    step();
    mem_wr_en = 1'b0;
    @(negedge clk);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_data2 !== e) begin
        n_err++;
        $display("FAIL byte_enable got=%h exp=%h", mem_rd_data2, e);
      end
    end
    $display("byte enable: load 0x10 -> %h", mem_rd_data2);
  endtask

  task automatic test_random_stores();
    logic [31:0] mdl [8];
    for (int i = 0; i < 8; i++) begin
      mdl[i] = $urandom;
      mem_addr2 = 32'h100 + 32'(i * 4);
      mem_wr_en = 1'b1; mem_wr_data = mdl[i]; mem_byte_en = 4'hF;
      step();
    end
    for (int n = 0; n < 24; n++) begin
      int w;
      w = $urandom_range(0, 7);
      mem_addr2 = 32'h100 + 32'(w * 4) + 32'($urandom_range(0, 3));
      mem_wr_data = $urandom;
      mem_byte_en = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) mdl[w][8*b +: 8] = mem_wr_data[8*b +: 8];
      step();
    end
    mem_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(mdl[i]);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      mem_addr1 = 32'h100 + 32'(i * 4);
      mem_addr2 = 32'h100 + 32'(i * 4) + 32'h3;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_data1 !== e || mem_rd_data2 !== e) begin
        n_err++;
        $display("FAIL rand_word%0d rd1=%h rd2=%h exp=%h", i, mem_rd_data1, mem_rd_data2, e);
      end
      $display("random: word %0d -> %h", i, mem_rd_data1);
      step();
    end
  endtask

  task automatic test_same_cycle();
    mem_addr2 = 32'h20;
    mem_wr_en = 1'b1; mem_wr_data = 32'h77; mem_byte_en = 4'hF;
    step();
    mem_addr1 = 32'h20;
    mem_wr_data = 32'h5;
    exp_q.push_back(32'h77);
    exp_q.push_back(32'h5);
    @(negedge clk);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_data1 !== e || mem_rd_data2 !== e) begin
        n_err++;
        $display("FAIL same_cycle_old rd1=%h rd2=%h exp=%h", mem_rd_data1, mem_rd_data2, e);
      end
      step();
      mem_wr_en = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_data1 !== e || mem_rd_data2 !== e) begin
        n_err++;
        $display("FAIL same_cycle_new rd1=%h rd2=%h exp=%h", mem_rd_data1, mem_rd_data2, e);
      end
    end
    $display("same cycle: after write rd1=%h rd2=%h", mem_rd_data1, mem_rd_data2);
    step();
  endtask

  task automatic test_out_of_range();
    mem_addr1 = 32'h4000;
    mem_addr2 = 32'h4000;
    @(negedge clk);
    n_cmp++;
    if (mem_rd_data1 !== 32'h0 || mem_rd_data2 !== 32'h0) begin
      n_err++;
      $display("FAIL oob_read rd1=%h rd2=%h exp=0", mem_rd_data1, mem_rd_data2);
    end
    step();
    mem_wr_en = 1'b1; mem_wr_data = 32'hFFFF_FFFF; mem_byte_en = 4'hF;
    step();
    mem_wr_en = 1'b0;
    mem_addr1 = 32'h0;
    mem_addr2 = 32'h0;
    // 0x4000 aliases word 0 in its index bits, so a missing range check shows up here.
    exp_q.push_back(32'h11);
    @(negedge clk);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_data1 !== e) begin
        n_err++;
        $display("FAIL oob_write_dropped got=%h exp=%h", mem_rd_data1, e);
      end
    end
`ifdef MEM_BOUNDS_ERR_EN
    n_cmp++;
    if (err_oob !== 1'b1 || err_addr !== 32'h4000) begin
      n_err++;
      $display("FAIL oob_err oob=%b addr=%h exp 1/00004000", err_oob, err_addr);
    end
`endif
    $display("out of range: word 0 still %h", mem_rd_data1);
    step();
  endtask

  task automatic test_tohost();
    mem_addr2 = TOHOST;
    mem_wr_en = 1'b1; mem_wr_data = 32'h2; mem_byte_en = 4'h0;
    step();
    mem_wr_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tohost_data !== 32'h2 || tohost_done !== 1'b0 || core_hold !== 1'b0) begin
      n_err++;
      $display("FAIL tohost_2 data=%h done=%b hold=%b exp 2/0/0", tohost_data, tohost_done, core_hold);
    end
    n_cmp++;
    if (mem_rd_data2 !== 32'h2) begin
      n_err++;
      $display("FAIL tohost_readback got=%h exp=2", mem_rd_data2);
    end
    step();
    mem_wr_en = 1'b1; mem_wr_data = 32'h1;
    step();
    mem_wr_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tohost_data !== 32'h1 || tohost_done !== 1'b1 || core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL tohost_done data=%h done=%b hold=%b exp 1/1/1", tohost_data, tohost_done, core_hold);
    end
    $display("tohost: data=%h done=%b hold=%b", tohost_data, tohost_done, core_hold);
    step();
    mem_addr2 = 32'h0;
    mem_wr_en = 1'b1; mem_wr_data = 32'hCAFE; mem_byte_en = 4'hF;
    step();
    mem_addr2 = TOHOST; mem_wr_data = 32'h3;
    step();
    mem_wr_en = 1'b0;
    mem_addr1 = 32'h0;
    exp_q.push_back(32'h11);
    @(negedge clk);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_data1 !== e || tohost_data !== 32'h1) begin
        n_err++;
        $display("FAIL halt_writes_ignored word0=%h tohost=%h exp %h/1", mem_rd_data1, tohost_data, e);
      end
    end
    $display("halt: word 0 = %h tohost=%h", mem_rd_data1, tohost_data);
  endtask

  initial begin
    test_reset();
    test_reset_midload();
    test_boot_load();
    test_init_ignored();
    test_byte_enable();
    test_random_stores();
    test_same_cycle();
    test_out_of_range();
    test_tohost();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
